// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write vs. buffered divider results, 1-cycle registered output.
// Latency 1 cycle from grant to reg_*; backpressure via div_ready_o (FIFO full) and hold_flag_o (forced drain).
module wb_port_arbiter #(
    parameter int DIV_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_waddr_i,
    input  logic [31:0] pipe_wdata_i,
    input  logic        int_assert_i,
    input  logic        div_we_i,
    input  logic [4:0]  div_waddr_i,
    input  logic [31:0] div_wdata_i,
    output logic        div_ready_o,
    input  logic [4:0]  pend_raddr_i,
    output logic        pend_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        hold_flag_o,
    output logic        overflow_o
);
    localparam int PW = (DIV_FIFO_DEPTH > 1) ? $clog2(DIV_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(DIV_FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]                f_addr [DIV_FIFO_DEPTH];
    logic [31:0]               f_data [DIV_FIFO_DEPTH];
    logic [DIV_FIFO_DEPTH-1:0] f_live;
    logic [PW-1:0]             rd_ptr;
    logic [PW-1:0]             wr_ptr;
    logic [CW-1:0]             count;
    logic [SW-1:0]             starve;

    logic        empty, full, pw, force_pop, pipe_commit, pop, bypass, push, drop;
    logic        nxt_we;
    logic [4:0]  nxt_addr;
    logic [31:0] nxt_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DIV_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty       = (count == '0);
    assign full        = (count == CW'(DIV_FIFO_DEPTH));
    assign pw          = pipe_we_i & ~int_assert_i;
    assign force_pop   = ~empty & (starve == SW'(STARVE_LIMIT));
    assign pipe_commit = pw & ~force_pop;
    assign pop         = force_pop | (~pw & ~empty);
    assign bypass      = empty & ~pw & div_we_i;
    assign push        = div_we_i & ~bypass & ~full;
    assign drop        = div_we_i & ~bypass & full;

    assign div_ready_o = ~full;
    assign hold_flag_o = force_pop & pw;

    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < DIV_FIFO_DEPTH; i++) begin
            if (f_live[i] && (f_addr[i] == pend_raddr_i)) pend_o = 1'b1;
        end
        if (pend_raddr_i == 5'd0) pend_o = 1'b0;
    end

    // Invalidated heads and x0 targets still consume their grant but never write.
    always_comb begin
        nxt_we   = 1'b0;
        nxt_addr = 5'd0;
        nxt_data = 32'd0;
        if (pop) begin
            nxt_we   = f_live[rd_ptr] && (f_addr[rd_ptr] != 5'd0);
            nxt_addr = f_addr[rd_ptr];
            nxt_data = f_data[rd_ptr];
        end else if (pipe_commit) begin
            nxt_we   = (pipe_waddr_i != 5'd0);
            nxt_addr = pipe_waddr_i;
            nxt_data = pipe_wdata_i;
        end else if (bypass) begin
            nxt_we   = (div_waddr_i != 5'd0);
            nxt_addr = div_waddr_i;
            nxt_data = div_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr] <= div_waddr_i;
            f_data[wr_ptr] <= div_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_live     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve     <= '0;
            overflow_o <= 1'b0;
        end else begin
            // A committed pipe write supersedes older queued results to the same register.
            if (pipe_commit) begin
                for (int i = 0; i < DIV_FIFO_DEPTH; i++) begin
                    if (f_addr[i] == pipe_waddr_i) f_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                f_live[rd_ptr] <= 1'b0;
                rd_ptr         <= ptr_inc(rd_ptr);
            end
            if (push) begin
                f_live[wr_ptr] <= 1'b1;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop) overflow_o <= 1'b1;
            if (pop)                                         starve <= '0;
            else if (!empty && starve != SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_we_o    <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= 32'd0;
        end else begin
            reg_we_o    <= nxt_we;
            reg_waddr_o <= nxt_addr;
            reg_wdata_o <= nxt_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, corner sequences, random traffic vs. queue model.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we_i, int_assert_i, div_we_i;
    logic [4:0]  pipe_waddr_i, div_waddr_i, pend_raddr_i;
    logic [31:0] pipe_wdata_i, div_wdata_i;
    logic        div_ready_o, pend_o, reg_we_o, hold_flag_o, overflow_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DIV_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .int_assert_i(int_assert_i),
        .div_we_i(div_we_i), .div_waddr_i(div_waddr_i), .div_wdata_i(div_wdata_i),
        .div_ready_o(div_ready_o),
        .pend_raddr_i(pend_raddr_i), .pend_o(pend_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .hold_flag_o(hold_flag_o), .overflow_o(overflow_o)
    );

    typedef struct {
        logic pwe, ia; logic [4:0] pa; logic [31:0] pd;
        logic dwe; logic [4:0] da; logic [31:0] dd; logic [4:0] ra;
    } in_t;
    typedef struct {
        in_t i; logic pend, hold, we; logic [4:0] wa; logic [31:0] wd;
    } vec_t;
    typedef struct { logic [4:0] a; logic [31:0] d; bit live; } ent_t;

    ent_t q[$];
    int   m_starve;
    bit   m_ovf;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tab[11];
    vec_t none;

    function automatic in_t mk(bit pwe, bit ia, int pa, int pd, bit dwe, int da, int dd, int ra);
        in_t v;
        v.pwe = pwe; v.ia = ia; v.pa = 5'(pa); v.pd = 32'(pd);
        v.dwe = dwe; v.da = 5'(da); v.dd = 32'(dd); v.ra = 5'(ra);
        return v;
    endfunction

    function automatic vec_t mv(in_t i, bit pend, bit hold, bit we, int wa, int wd);
        vec_t t;
        t.i = i; t.pend = pend; t.hold = hold; t.we = we; t.wa = 5'(wa); t.wd = 32'(wd);
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(in_t v);
        pipe_we_i = v.pwe; int_assert_i = v.ia; pipe_waddr_i = v.pa; pipe_wdata_i = v.pd;
        div_we_i = v.dwe; div_waddr_i = v.da; div_wdata_i = v.dd; pend_raddr_i = v.ra;
    endtask

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_ovf    = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the model, check registered outputs.
    task automatic cycle(in_t v, bit use_tab, vec_t t);
        bit pw, popped, byp, e_we, e_hold, e_pend;
        logic [4:0] e_wa;
        logic [31:0] e_wd;
        int sz;
        ent_t h;
        @(negedge clk);
        drive(v);
        #1;
        e_pend = 0;
        foreach (q[k]) if (q[k].live && q[k].a == v.ra && v.ra != 0) e_pend = 1;
        pw     = v.pwe && !v.ia;
        sz     = q.size();
        e_hold = pw && sz > 0 && m_starve == LIMIT;
        check("pend", pend_o, e_pend);
        check("hold", hold_flag_o, e_hold);
        check("ready", div_ready_o, sz < DEPTH);
        check("overflow", overflow_o, m_ovf);
        if (use_tab) begin
            check("tab_pend", pend_o, t.pend);
            check("tab_hold", hold_flag_o, t.hold);
        end
        e_we = 0; e_wa = 0; e_wd = 0; popped = 0; byp = 0;
        if (sz > 0 && m_starve == LIMIT) begin
            h = q.pop_front(); popped = 1;
            e_we = h.live && h.a != 0; e_wa = h.a; e_wd = h.d;
        end else if (pw) begin
            e_we = v.pa != 0; e_wa = v.pa; e_wd = v.pd;
            foreach (q[k]) if (q[k].a == v.pa) q[k].live = 0;
        end else if (sz > 0) begin
            h = q.pop_front(); popped = 1;
            e_we = h.live && h.a != 0; e_wa = h.a; e_wd = h.d;
        end else if (v.dwe) begin
            byp = 1;
            e_we = v.da != 0; e_wa = v.da; e_wd = v.dd;
        end
        if (v.dwe && !byp) begin
            if (sz >= DEPTH) m_ovf = 1;
            else q.push_back('{v.da, v.dd, 1'b1});
        end
        if (popped) m_starve = 0;
        else if (sz > 0 && m_starve < LIMIT) m_starve++;
        @(posedge clk);
        #1;
        check("reg_we", reg_we_o, e_we);
        if (e_we) begin
            check("reg_waddr", reg_waddr_o, e_wa);
            check("reg_wdata", reg_wdata_o, e_wd);
        end
        if (use_tab) begin
            check("tab_we", reg_we_o, t.we);
            if (t.we) begin
                check("tab_waddr", reg_waddr_o, t.wa);
                check("tab_wdata", reg_wdata_o, t.wd);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        in_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        none = mv(idle, 0, 0, 0, 0, 0);
        tab[0]  = mv(mk(0, 0, 0, 0,     1, 5, 'h1234, 0), 0, 0, 1, 5, 'h1234);
        tab[1]  = mv(mk(1, 0, 3, 'h11,  1, 7, 'h22,   0), 0, 0, 1, 3, 'h11);
        tab[2]  = mv(mk(0, 0, 0, 0,     0, 0, 0,      7), 1, 0, 1, 7, 'h22);
        tab[3]  = mv(mk(0, 0, 0, 0,     0, 0, 0,      7), 0, 0, 0, 0, 0);
        tab[4]  = mv(mk(1, 0, 1, 'h1,   1, 4, 'h55,   0), 0, 0, 1, 1, 'h1);
        tab[5]  = mv(mk(1, 0, 4, 'hAA,  0, 0, 0,      4), 1, 0, 1, 4, 'hAA);
        tab[6]  = mv(mk(0, 0, 0, 0,     0, 0, 0,      4), 0, 0, 0, 0, 0);
        tab[7]  = mv(idle,                                0, 0, 0, 0, 0);
        tab[8]  = mv(mk(0, 0, 0, 0,     1, 0, 'h99,   0), 0, 0, 0, 0, 0);
        tab[9]  = mv(mk(1, 1, 2, 'h77,  0, 0, 0,      0), 0, 0, 0, 0, 0);
        tab[10] = mv(mk(1, 0, 0, 'h66,  0, 0, 0,      0), 0, 0, 0, 0, 0);

        rst = 1'b0;
        drive(idle);
        model_reset();
        #12;
        check("rst_we", reg_we_o, 0);
        check("rst_waddr", reg_waddr_o, 0);
        check("rst_wdata", reg_wdata_o, 0);
        check("rst_ready", div_ready_o, 1);
        check("rst_hold", hold_flag_o, 0);
        check("rst_ovf", overflow_o, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 11; k++) cycle(tab[k].i, 1, tab[k]);

        // Starvation: x9 queued behind a continuously busy pipeline.
        do_reset();
        cycle(mk(1, 0, 1, 'h100, 1, 9, 'h99, 9), 1, mv(idle, 0, 0, 1, 1, 'h100));
        for (int k = 0; k < LIMIT; k++)
            cycle(mk(1, 0, 2 + k, 'h200 + k, 0, 0, 0, 9), 1, mv(idle, 1, 0, 1, 2 + k, 'h200 + k));
        cycle(mk(1, 0, 6, 'h600, 0, 0, 0, 9), 1, mv(idle, 1, 1, 1, 9, 'h99));
        cycle(mk(1, 0, 6, 'h600, 0, 0, 0, 9), 1, mv(idle, 0, 0, 1, 6, 'h600));

        // Full FIFO and overflow.
        do_reset();
        cycle(mk(1, 0, 1, 'h1, 1, 10, 'hA0, 0), 0, none);
        cycle(mk(1, 0, 2, 'h2, 1, 11, 'hB0, 0), 0, none);
        check("ready_full", div_ready_o, 0);
        cycle(mk(1, 0, 3, 'h3, 1, 12, 'hC0, 12), 0, none);
        check("ovf_set", overflow_o, 1);
        cycle(idle, 1, mv(idle, 0, 0, 1, 10, 'hA0));
        cycle(idle, 1, mv(idle, 0, 0, 1, 11, 'hB0));
        cycle(idle, 1, mv(idle, 0, 0, 0, 0, 0));
        check("ovf_sticky", overflow_o, 1);

        // Asynchronous reset mid-traffic discards queued results.
        do_reset();
        cycle(mk(1, 0, 1, 'h1, 1, 13, 'hD0, 0), 0, none);
        cycle(mk(1, 0, 2, 'h2, 1, 14, 'hE0, 0), 0, none);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 13));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_we", reg_we_o, 0);
        check("mid_rst_waddr", reg_waddr_o, 0);
        check("mid_rst_wdata", reg_wdata_o, 0);
        check("mid_rst_ready", div_ready_o, 1);
        check("mid_rst_pend", pend_o, 0);
        check("mid_rst_hold", hold_flag_o, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 13), 1, mv(idle, 0, 0, 0, 0, 0));

        // Random traffic against the queue model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_t r;
            r = mk($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                   int'($urandom_range(0, 7)), int'($urandom),
                   $urandom_range(0, 9) < 3, int'($urandom_range(0, 7)), int'($urandom),
                   int'($urandom_range(0, 7)));
            cycle(r, 0, none);
            if (k == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
